// File: rtl/seq_binary_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// A start/ready handshake launches a conversion. The result and the overflow flag
// are registered and held until the next valid pulse. A value that does not fit
// in DIGITS decimal digits is shown as all nines, with overflow set.
module seq_binary_to_bcd #(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      binary,
    output logic                  ready,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned CAT_W = BCD_W + BIN_W + 1;

    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [BIN_W-1:0]   shift_q,  shift_d;
    logic [BCD_W-1:0]   work_q,   work_d;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [BCD_W-1:0]   bcd_q,    bcd_d;
    logic               ovf_q,    ovf_d;
    logic               valid_q,  valid_d;

    logic [BCD_W-1:0]   adj;
    logic [CAT_W-1:0]   shifted;

    // Per-digit add-3 correction, then a one-bit left shift of {work, input}.
    // The extra bit at the top catches the digit carried out of the top digit.
    always_comb begin
        adj = work_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, shift_q, 1'b0};
    end

    // Next-state and datapath control for IDLE -> CONV -> DONE -> IDLE.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        work_d   = work_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d  = binary;
                    work_d   = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CNT_LOAD;
                    state_d  = S_CONV;
                end
            end

            S_CONV: begin
                work_d   = shifted[CAT_W-2 -: BCD_W];
                shift_d  = shifted[BIN_W-1:0];
                sticky_d = sticky_q | shifted[CAT_W-1];
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                bcd_d   = sticky_q ? ALL_NINES : work_q;
                ovf_d   = sticky_q;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            work_q   <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            work_q   <= work_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign valid    = valid_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// Directed bench for seq_binary_to_bcd. Three instances are used: 8-bit/3 digits,
// the defaults (16-bit/5 digits), and 8-bit/2 digits for saturation.
module tb_seq_binary_to_bcd;

    typedef struct packed {
        logic        ovf;
        logic [19:0] bcd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_s [3];
    logic [15:0] bin_s   [3];
    logic        ready_s [3];
    logic        busy_s  [3];
    logic        valid_s [3];
    logic [11:0] bcd_a;
    logic [19:0] bcd_b;
    logic [7:0]  bcd_c;
    logic        ovf_s   [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int nchk = 0;
    int nerr = 0;
    int edge_n = 0;
    int acc_a = 0;
    int b_prev = -1;
    logic held = 1'b0;
    logic pv_s [3];

    always #5 clk = ~clk;

    seq_binary_to_bcd #(.BIN_W(8), .DIGITS(3)) u_a (
        .clk(clk), .reset(reset), .start(start_s[0]), .binary(bin_s[0][7:0]),
        .ready(ready_s[0]), .busy(busy_s[0]), .valid(valid_s[0]),
        .bcd(bcd_a), .overflow(ovf_s[0])
    );

    seq_binary_to_bcd u_b (
        .clk(clk), .reset(reset), .start(start_s[1]), .binary(bin_s[1]),
        .ready(ready_s[1]), .busy(busy_s[1]), .valid(valid_s[1]),
        .bcd(bcd_b), .overflow(ovf_s[1])
    );

    seq_binary_to_bcd #(.BIN_W(8), .DIGITS(2)) u_c (
        .clk(clk), .reset(reset), .start(start_s[2]), .binary(bin_s[2][7:0]),
        .ready(ready_s[2]), .busy(busy_s[2]), .valid(valid_s[2]),
        .bcd(bcd_c), .overflow(ovf_s[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits of v, saturated to all nines when v >= 10^digits.
    function automatic exp_t model(input int v, input int digits);
        exp_t r;
        int   lim = 1;
        int   t   = v;
        r = '0;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        if (v >= lim) begin
            r.ovf = 1'b1;
            for (int i = 0; i < digits; i++) r.bcd[4*i +: 4] = 4'h9;
        end else begin
            for (int i = 0; i < digits; i++) begin
                r.bcd[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
        return r;
    endfunction

    // Edge counter and acceptance time of the 8-bit/3-digit instance.
    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (!reset && ready_s[0] && start_s[0]) acc_a <= edge_n + 1;
    end

    // Scoreboard pop and per-cycle invariants.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("rdy_xor_busy_%0d", d), {31'd0, ready_s[d] ^ busy_s[d]}, 32'd1);
                if (valid_s[d]) chk($sformatf("valid_pulse_%0d", d), {31'd0, pv_s[d]}, 32'd0);
                pv_s[d] = valid_s[d];
            end
            if (valid_s[0]) begin
                if (q0.size() == 0) chk("a_spurious_valid", 32'd1, {31'd0, valid_s[0] & 1'b0});
                else begin
                    e = q0.pop_front();
                    chk("a_bcd", {20'd0, bcd_a}, {12'd0, e.bcd});
                    chk("a_ovf", {31'd0, ovf_s[0]}, {31'd0, e.ovf});
                    chk("a_latency", edge_n - acc_a, 32'd9);
                end
            end
            if (valid_s[1]) begin
                if (q1.size() == 0) chk("b_spurious_valid", 32'd1, {31'd0, valid_s[1] & 1'b0});
                else begin
                    e = q1.pop_front();
                    chk("b_bcd", {12'd0, bcd_b}, {12'd0, e.bcd});
                    chk("b_ovf", {31'd0, ovf_s[1]}, {31'd0, e.ovf});
                end
                if (held) begin
                    if (b_prev >= 0) chk("b_valid_spacing", edge_n - b_prev, 32'd18);
                    b_prev = edge_n;
                end
            end
            if (valid_s[2]) begin
                if (q2.size() == 0) chk("c_spurious_valid", 32'd1, {31'd0, valid_s[2] & 1'b0});
                else begin
                    e = q2.pop_front();
                    chk("c_bcd", {24'd0, bcd_c}, {12'd0, e.bcd});
                    chk("c_ovf", {31'd0, ovf_s[2]}, {31'd0, e.ovf});
                end
            end
        end else begin
            for (int d = 0; d < 3; d++) pv_s[d] = 1'b0;
        end
    end

    // Wait for ready on instance d, then pulse start for one edge; optionally score it.
    task automatic go(input int d, input int v, input bit push);
        int n = 0;
        @(negedge clk);
        while (!ready_s[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("ready_wait_%0d", d), {31'd0, ready_s[d]}, 32'd1);
        start_s[d] = 1'b1;
        bin_s[d]   = 16'(v);
        if (push) begin
            case (d)
                0: q0.push_back(model(v, 3));
                1: q1.push_back(model(v, 5));
                default: q2.push_back(model(v, 2));
            endcase
        end
        @(posedge clk);
        #1 start_s[d] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 400) begin
            @(negedge clk);
            #1 n++;
        end
        chk("drain_outstanding", q0.size() + q1.size() + q2.size(), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0;
            bin_s[d]   = '0;
            pv_s[d]    = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_ready_%0d", d), {31'd0, ready_s[d]}, 32'd1);
            chk($sformatf("rst_busy_%0d", d),  {31'd0, busy_s[d]},  32'd0);
            chk($sformatf("rst_valid_%0d", d), {31'd0, valid_s[d]}, 32'd0);
            chk($sformatf("rst_ovf_%0d", d),   {31'd0, ovf_s[d]},   32'd0);
        end
        chk("rst_bcd_a", {20'd0, bcd_a}, 32'd0);
        chk("rst_bcd_b", {12'd0, bcd_b}, 32'd0);
        chk("rst_bcd_c", {24'd0, bcd_c}, 32'd0);

        // 8-bit / 3 digits: full-scale value and latency
        go(0, 255, 1'b1);
        go(0, 1, 1'b1);
        drain();

        // defaults: zero, full scale, mixed digits
        go(1, 0, 1'b1);
        go(1, 65535, 1'b1);
        go(1, 40960, 1'b1);
        drain();

        // 8-bit / 2 digits: edge of range, saturation, sticky cleared again
        go(2, 99, 1'b1);
        go(2, 100, 1'b1);
        go(2, 250, 1'b1);
        go(2, 7, 1'b1);
        drain();

        // start while busy is ignored
        go(1, 1111, 1'b1);
        @(posedge clk);
        @(negedge clk);
        start_s[1] = 1'b1;
        bin_s[1]   = 16'd2222;
        chk("b_ready_while_busy", {31'd0, ready_s[1]}, 32'd0);
        @(posedge clk);
        #1 start_s[1] = 1'b0;
        @(negedge clk);
        chk("b_ready_still_low", {31'd0, ready_s[1]}, 32'd0);
        drain();

        // start held high: accepted at E, E+18, E+36, E+54 over 60 edges
        @(negedge clk);
        held   = 1'b1;
        b_prev = -1;
        start_s[1] = 1'b1;
        bin_s[1]   = 16'd4321;
        for (int i = 0; i < 4; i++) q1.push_back(model(4321, 5));
        repeat (60) @(posedge clk);
        #1 start_s[1] = 1'b0;
        drain();
        held = 1'b0;

        // reset in the middle of a conversion abandons it
        go(1, 5555, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ready", {31'd0, ready_s[1]}, 32'd1);
        chk("mid_rst_busy",  {31'd0, busy_s[1]},  32'd0);
        chk("mid_rst_valid", {31'd0, valid_s[1]}, 32'd0);
        chk("mid_rst_bcd",   {12'd0, bcd_b},      32'd0);
        chk("mid_rst_ovf",   {31'd0, ovf_s[1]},   32'd0);
        reset = 1'b0;
        repeat (25) @(posedge clk);
        go(1, 1234, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
